// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with programmable pattern and length,
// overlap select, input-valid qualifier and saturating match counter.
//
// Ports:
//   clk, rst          clock and async active-high reset
//   cfg_we            load cfg_pattern/cfg_len/cfg_overlap, clear history
//   cfg_pattern       pattern, bit [len-1] is received first
//   cfg_len           pattern length, clamped to MAX_LEN, 0 disables
//   cfg_overlap       1 = overlapping detection
//   in_valid, inp     serial bit and its qualifier
//   cnt_clr           synchronous clear of match_count
//   outp              registered one-cycle match pulse
//   match_count       saturating match count
//   fill              valid history bits, saturating at active length
module seq_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = 8'b0001_1010,
  parameter int RST_LEN = 5,
  parameter logic RST_OVERLAP = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               inp,
  input  logic               cnt_clr,
  output logic               outp,
  output logic [CNT_W-1:0]   match_count,
  output logic [LEN_W-1:0]   fill
);

  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               overlap_q, overlap_d;
  logic               outp_q, outp_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               acc;
  logic               match;
  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] hist_n;
  logic [LEN_W:0]     fill_inc;
  logic [LEN_W-1:0]   fill_n;

  always_comb begin
    for (int i = 0; i < MAX_LEN; i++)
      mask[i] = (i < int'(len_q));
  end

  always_comb begin
    acc      = in_valid & ~cfg_we;
    hist_n   = {hist_q[MAX_LEN-2:0], inp};
    fill_inc = {1'b0, fill_q} + 1'b1;
    fill_n   = (fill_inc >= {1'b0, len_q}) ?
               len_q : fill_inc[LEN_W-1:0];
    match    = acc && (len_q != '0) &&
               (fill_n == len_q) &&
               (((hist_n ^ pattern_q) & mask) == '0);

    hist_d    = hist_q;
    fill_d    = fill_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    outp_d    = match;
    cnt_d     = cnt_q;

    if (cfg_we) begin
      pattern_d = cfg_pattern;
      len_d     = (cfg_len > MAX_L) ? MAX_L : cfg_len;
      overlap_d = cfg_overlap;
      hist_d    = '0;
      fill_d    = '0;
    end else if (acc) begin
      hist_d = hist_n;
      // non-overlap restarts the fill so the next hit needs len new bits
      fill_d = (match && !overlap_q) ? '0 : fill_n;
    end

    if (cnt_clr)
      cnt_d = '0;
    else if (match && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q    <= '0;
      fill_q    <= '0;
      pattern_q <= RST_PATTERN;
      len_q     <= LEN_W'(RST_LEN);
      overlap_q <= RST_OVERLAP;
      outp_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      outp_q    <= outp_d;
      cnt_q     <= cnt_d;
    end
  end

  assign outp        = outp_q;
  assign match_count = cnt_q;
  assign fill        = fill_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed self-checking bench for seq_detector_param.
// A second instance with CNT_W=2 covers counter saturation.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic       in_valid = 1'b0;
  logic       inp = 1'b0;
  logic       cnt_clr = 1'b0;

  logic       outp, outp2;
  logic [7:0] cnt;
  logic [1:0] cnt2;
  logic [3:0] fill, fill2;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_detector_param dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .in_valid(in_valid),
    .inp(inp), .cnt_clr(cnt_clr), .outp(outp),
    .match_count(cnt), .fill(fill)
  );

  seq_detector_param #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .in_valid(in_valid),
    .inp(inp), .cnt_clr(cnt_clr), .outp(outp2),
    .match_count(cnt2), .fill(fill2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    #2;
    chk("rst_outp", 32'(outp), 0);
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_fill", 32'(fill), 0);
    rst = 1'b0;
  endtask

  task automatic cfg(input logic [7:0] p,
                     input logic [3:0] l,
                     input logic o);
    cfg_we = 1'b1;
    cfg_pattern = p;
    cfg_len = l;
    cfg_overlap = o;
    tick();
    cfg_we = 1'b0;
    chk("cfg_outp", 32'(outp), 0);
    chk("cfg_fill", 32'(fill), 0);
  endtask

  task automatic bit_in(input string tag,
                        input logic b,
                        input logic exp);
    in_valid = 1'b1;
    inp = b;
    tick();
    in_valid = 1'b0;
    chk(tag, 32'(outp), 32'(exp));
  endtask

  task automatic idle();
    in_valid = 1'b0;
    inp = 1'b1;
    tick();
    chk("gap_outp", 32'(outp), 0);
  endtask

  initial begin
    logic [10:0] s, o;
    logic [4:0]  s5;
    logic [7:0]  s8;

    // defaults, legacy 11010 overlapping
    do_rst();
    s = 11'b01101011010;
    o = 11'b00000100001;
    for (int i = 0; i < 11; i++) begin
      bit_in("t1_outp", s[10-i], o[10-i]);
      chk("t1_fill", 32'(fill), (i < 5) ? i + 1 : 5);
    end
    chk("t1_cnt", 32'(cnt), 2);

    // 101 overlap
    do_rst();
    cfg(8'b101, 4'd3, 1'b1);
    bit_in("t2_o", 1'b1, 1'b0);
    bit_in("t2_o", 1'b0, 1'b0);
    bit_in("t2_o", 1'b1, 1'b1);
    bit_in("t2_o", 1'b0, 1'b0);
    bit_in("t2_o", 1'b1, 1'b1);
    chk("t2_cnt", 32'(cnt), 2);

    // 101 non-overlap
    do_rst();
    cfg(8'b101, 4'd3, 1'b0);
    bit_in("t3_o", 1'b1, 1'b0);
    bit_in("t3_o", 1'b0, 1'b0);
    bit_in("t3_o", 1'b1, 1'b1);
    chk("t3_fill", 32'(fill), 0);
    bit_in("t3_o", 1'b0, 1'b0);
    bit_in("t3_o", 1'b1, 1'b0);
    chk("t3_cnt", 32'(cnt), 1);

    // in_valid gaps
    do_rst();
    bit_in("t4_o", 1'b1, 1'b0);
    bit_in("t4_o", 1'b1, 1'b0);
    idle();
    idle();
    idle();
    chk("t4_fill", 32'(fill), 2);
    bit_in("t4_o", 1'b0, 1'b0);
    bit_in("t4_o", 1'b1, 1'b0);
    bit_in("t4_o", 1'b0, 1'b1);
    chk("t4_cnt", 32'(cnt), 1);

    // cfg_we drops the simultaneous bit
    do_rst();
    bit_in("t5_o", 1'b1, 1'b0);
    bit_in("t5_o", 1'b1, 1'b0);
    bit_in("t5_o", 1'b0, 1'b0);
    in_valid = 1'b1;
    inp = 1'b1;
    cfg(8'b0001_1010, 4'd5, 1'b1);
    bit_in("t5_drop", 1'b0, 1'b0);
    chk("t5_fill", 32'(fill), 1);
    s5 = 5'b11010;
    for (int i = 0; i < 5; i++)
      bit_in("t5_o", s5[4-i], i == 4);
    chk("t5_cnt", 32'(cnt), 1);

    // saturating 2-bit counter, clear beats match
    do_rst();
    cfg(8'b1, 4'd1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      bit_in("t6_o", 1'b1, 1'b1);
      chk("t6_cnt2", 32'(cnt2), (i < 3) ? i + 1 : 3);
    end
    cnt_clr = 1'b1;
    bit_in("t6_clr_o", 1'b1, 1'b1);
    cnt_clr = 1'b0;
    chk("t6_clr_cnt2", 32'(cnt2), 0);
    chk("t6_clr_cnt", 32'(cnt), 0);

    // len 0 disables
    do_rst();
    cfg(8'b0, 4'd0, 1'b1);
    for (int i = 0; i < 4; i++)
      bit_in("t7_o", i[0], 1'b0);
    chk("t7_fill", 32'(fill), 0);
    chk("t7_cnt", 32'(cnt), 0);

    // cfg_len 15 clamps to 8
    do_rst();
    cfg(8'b1010_0110, 4'd15, 1'b1);
    s8 = 8'b1010_0110;
    for (int i = 0; i < 8; i++)
      bit_in("t8_o", s8[7-i], i == 7);
    chk("t8_fill", 32'(fill), 8);
    bit_in("t8_o", 1'b1, 1'b0);
    chk("t8_fill_sat", 32'(fill), 8);

    // async reset mid-stream restores defaults
    do_rst();
    cfg(8'b11, 4'd2, 1'b1);
    bit_in("t9_o", 1'b1, 1'b0);
    bit_in("t9_o", 1'b1, 1'b1);
    chk("t9_pre_cnt", 32'(cnt), 1);
    chk("t9_pre_fill", 32'(fill), 2);
    do_rst();
    s5 = 5'b11010;
    for (int i = 0; i < 5; i++)
      bit_in("t9_o", s5[4-i], i == 4);
    chk("t9_cnt", 32'(cnt), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial bit-pattern detector, the next-generation replacement for the fixed 11010 Mealy detector in the Sequence_detector area. It has a runtime-programmable pattern of 1..MAX_LEN bits, selectable overlapping or non-overlapping detection, an input-valid qualifier, and a saturating match counter. It sits on a 1-bit serial stream and produces a registered one-cycle match pulse for downstream control logic.

## Interface
- MAX_LEN, 8: maximum pattern length in bits; must be >= 2.
- LEN_W, 4: width of length fields; must hold MAX_LEN.
- CNT_W, 8: width of the match counter.
- RST_PATTERN, 8'b0001_1010: pattern after reset; the low RST_LEN bits are used (11010).
- RST_LEN, 5: pattern length after reset.
- RST_OVERLAP, 1: overlap mode after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cfg_we  in  1  load cfg_pattern, cfg_len and cfg_overlap this cycle.
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] is the last.
- cfg_len  in  LEN_W  pattern length.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- in_valid  in  1  inp is sampled only when this is high.
- inp  in  1  serial data bit.
- cnt_clr  in  1  synchronous clear of match_count.
- outp  out  1  registered match pulse.
- match_count  out  CNT_W  saturating count of matches.
- fill  out  LEN_W  number of valid history bits since the last restart, saturating at the active length.

## Operation
- Internal state:
  - hist: MAX_LEN-bit shift register; hist[0] is the newest bit.
  - fill: counter of valid history bits.
  - pattern, len, overlap: active configuration registers.
- Accepted bit (in_valid=1, cfg_we=0):
  - Shift: hist_n = {hist[MAX_LEN-2:0], inp}.
  - Next fill: fill_n = min(fill+1, len).
- Match condition: accepted bit AND len != 0 AND fill_n == len AND hist_n[len-1:0] == pattern[len-1:0].
- On match:
  - Overlap=1: fill stays at len, so a later match may reuse bits.
  - Overlap=0: fill is set to 0 and hist is kept, so the next match needs len fresh bits.
- No accepted bit (in_valid=0): hist and fill hold, outp goes to 0.
- cfg_we=1 loads the configuration and clears hist and fill to 0. This takes priority over in_valid, so a bit presented in the same cycle is dropped.
- Length rules:
  - len is stored as min(cfg_len, MAX_LEN).
  - len=0 disables detection: outp stays 0 while hist and fill still update.
- match_count:
  - Increments on each match and saturates at 2^CNT_W-1.
  - cnt_clr=1 sets it to 0, and clear wins over a simultaneous match.
- Reset values:
  - outp=0, match_count=0, fill=0, hist=0.
  - pattern=RST_PATTERN, len=RST_LEN, overlap=RST_OVERLAP.
  - With the defaults, behaviour matches the legacy 11010 detector on a continuously valid stream.

## Timing
- Latency: outp rises on the clock edge that samples the completing bit and is high for exactly one cycle per match.
  - This is the same one-cycle registered Mealy timing as the legacy block.
- Back-to-back matches on consecutive valid bits give consecutive high cycles on outp. Example: pattern 11, overlap=1.
- match_count updates on the same edge as outp.
- fill updates on each accepted bit.
- A cfg_we pulse takes effect on its own edge. The next accepted bit is compared against the new pattern, and outp is 0 on the cfg_we edge.
- Asynchronous rst mid-stream: all outputs drop immediately, and any partial match is lost.
- Gaps in in_valid are transparent: a pattern split by any number of invalid cycles is still detected.

## Test plan
- Defaults, continuous stream 0,1,1,0,1,0,1,1,0,1,0 -> outp high on the edges sampling bits 6 and 11; match_count=2; fill never exceeds 5.
- cfg pattern=3'b101, len=3, overlap=1; stream 1,0,1,0,1 -> outp high on bits 3 and 5; count=2. Repeat with overlap=0 -> only bit 3 matches; count=1.
- in_valid gaps: 1,1,(3 invalid cycles),0,1,0 with defaults -> a single outp pulse on the final valid edge; outp is 0 during the gaps.
- cfg_we with in_valid=1 in the same cycle, partway through 1101 -> the bit is dropped, fill=0, no false match; a fresh 11010 then detects.
- CNT_W=2, pattern 1 with len=1, six valid 1s -> count goes 1,2,3,3,3,3. cnt_clr coinciding with a match -> count=0.
- len=0 -> no outp for any stream. cfg_len=15 with MAX_LEN=8 -> acts as len 8. rst asserted mid-pattern -> outp, count and fill are 0 asynchronously, and the default pattern is restored.
